alu_ctrl_seq: RTL and testbench

//  Registered, stall-aware successor to the combinational ALU control decoder; sits at the ID/EX boundary.

---
 rtl/alu_ctrl_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decoder with multi-cycle sequencing
// Optional DIV/DIVU support is enabled by defining ALUCTRL_DIV_EN.
module alu_ctrl_seq #(
  parameter int ALUOP_W = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_Valid,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               I21,
  input  logic               I6,
  input  logic               I16,
  input  logic               Flush,
  output logic               Stall,
  output logic               Out_Valid,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               HiLoWrite,
  output logic               Illegal
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MUL_BUSY = 2'd1;
`ifdef ALUCTRL_DIV_EN
  localparam logic [1:0] S_DIV_BUSY = 2'd2;
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_LAT - 1);
`endif
  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);

  if ((MUL_LAT < 1) || (DIV_LAT < 1) ||
      ((MUL_LAT - 1) >= (1 << CNT_W)) || ((DIV_LAT - 1) >= (1 << CNT_W))) begin : g_bad_params
    $error("alu_ctrl_seq: latency parameters do not fit CNT_W");
  end

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic               hilo_q, hilo_d;
  logic               illegal_q, illegal_d;

  logic [4:0] dec_code;
  logic       dec_ill;
  logic       dec_mul;
`ifdef ALUCTRL_DIV_EN
  logic       dec_div;
`endif

  // Illegal encodings leave dec_code at 0 so ALUOp reads 0 alongside Illegal.
  always_comb begin
    dec_code = 5'd0;
    dec_ill  = 1'b0;
    dec_mul  = 1'b0;
`ifdef ALUCTRL_DIV_EN
    dec_div  = 1'b0;
`endif
    case (Opcode)
      6'd0: begin
        case (Funct)
          6'd0:         dec_code = 5'd6;
          6'd2:         dec_code = I21 ? 5'd9 : 5'd4;
          6'd3:         dec_code = 5'd8;
          6'd4:         dec_code = 5'd7;
          6'd6:         dec_code = I6 ? 5'd10 : 5'd5;
          6'd7:         dec_code = 5'd11;
          6'd16:        dec_code = 5'd28;
          6'd17:        dec_code = 5'd2;
          6'd18:        dec_code = 5'd29;
          6'd19:        dec_code = 5'd3;
          6'd24:        begin dec_code = 5'd20; dec_mul = 1'b1; end
          6'd25:        begin dec_code = 5'd21; dec_mul = 1'b1; end
`ifdef ALUCTRL_DIV_EN
          6'd26:        begin dec_code = 5'd26; dec_div = 1'b1; end
          6'd27:        begin dec_code = 5'd27; dec_div = 1'b1; end
`endif
          6'd32, 6'd33: dec_code = 5'd13;
          6'd34, 6'd35: dec_code = 5'd14;
          6'd36:        dec_code = 5'd0;
          6'd37:        dec_code = 5'd1;
          6'd38:        dec_code = 5'd15;
          6'd39:        dec_code = 5'd16;
          6'd42:        dec_code = 5'd17;
          6'd43:        dec_code = 5'd19;
          default:      dec_ill  = 1'b1;
        endcase
      end
      6'd1:          dec_code = I16 ? 5'd18 : 5'd12;
      6'd4:          dec_code = 5'd24;
      6'd5:          dec_code = 5'd25;
      6'd8, 6'd9:    dec_code = 5'd13;
      6'd10:         dec_code = 5'd17;
      6'd11:         dec_code = 5'd19;
      6'd12:         dec_code = 5'd0;
      6'd13:         dec_code = 5'd1;
      6'd14:         dec_code = 5'd15;
      6'd15:         dec_code = 5'd23;
      6'd35, 6'd43:  dec_code = 5'd13;
      6'd28: begin
        case (Funct)
          6'd0, 6'd2: begin dec_code = 5'd31; dec_mul = 1'b1; end
          6'd4:       begin dec_code = 5'd22; dec_mul = 1'b1; end
          default:    dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Flush overrides both a new accept and an expiring countdown.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    hilo_d      = 1'b0;
    aluop_d     = aluop_q;
    illegal_d   = illegal_q;
    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (In_Valid) begin
        aluop_d   = ALUOP_W'(dec_code);
        illegal_d = dec_ill;
        if (dec_mul) begin
          state_d = S_MUL_BUSY;
          cnt_d   = MUL_CNT0;
        end
`ifdef ALUCTRL_DIV_EN
        else if (dec_div) begin
          state_d = S_DIV_BUSY;
          cnt_d   = DIV_CNT0;
        end
`endif
        else begin
          out_valid_d = 1'b1;
        end
      end
    end else begin
      if (cnt_q == '0) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        hilo_d      = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      aluop_q     <= '0;
      hilo_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      aluop_q     <= aluop_d;
      hilo_q      <= hilo_d;
      illegal_q   <= illegal_d;
    end
  end

  assign Stall     = (state_q != S_IDLE);
  assign Out_Valid = out_valid_q;
  assign ALUOp     = aluop_q;
  assign HiLoWrite = hilo_q;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - randomized and directed self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       In_Valid, I21, I6, I16, Flush;
  logic [5:0] Opcode, Funct;
  logic       Stall, Out_Valid, HiLoWrite, Illegal;
  logic [4:0] ALUOp;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining busy cycles plus last published outputs.
  int m_rem;
  bit m_ov, m_hl, m_ill, m_acc;
  int m_op;

  alu_ctrl_seq dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .Opcode(Opcode), .Funct(Funct),
    .I21(I21), .I6(I6), .I16(I16), .Flush(Flush), .Stall(Stall),
    .Out_Valid(Out_Valid), .ALUOp(ALUOp), .HiLoWrite(HiLoWrite), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  wire [8:0] dut_vec = {Stall, Out_Valid, HiLoWrite, Illegal, ALUOp};

  function automatic logic [8:0] model_out();
    logic [4:0] op5;
    op5 = m_op[4:0];
    return {m_rem != 0, m_ov, m_hl, m_ill, op5};
  endfunction

  task automatic ref_decode(input int op, input int fn, input bit i21, input bit i6, input bit i16,
                            output int code, output bit ill, output int lat);
    code = 0; ill = 0; lat = 0;
    if (op == 0) begin
      case (fn)
        0: code = 6;   2: code = i21 ? 9 : 4;  3: code = 8;   4: code = 7;
        6: code = i6 ? 10 : 5;                 7: code = 11;
        16: code = 28; 17: code = 2; 18: code = 29; 19: code = 3;
        24: begin code = 20; lat = MUL_LAT; end
        25: begin code = 21; lat = MUL_LAT; end
`ifdef ALUCTRL_DIV_EN
        26: begin code = 26; lat = DIV_LAT; end
        27: begin code = 27; lat = DIV_LAT; end
`endif
        32, 33: code = 13; 34, 35: code = 14; 36: code = 0; 37: code = 1;
        38: code = 15; 39: code = 16; 42: code = 17; 43: code = 19;
        default: ill = 1;
      endcase
    end else if (op == 1) code = i16 ? 18 : 12;
    else if (op == 28) begin
      if (fn == 0 || fn == 2) begin code = 31; lat = MUL_LAT; end
      else if (fn == 4) begin code = 22; lat = MUL_LAT; end
      else ill = 1;
    end else begin
      case (op)
        4: code = 24;  5: code = 25;  8, 9: code = 13;  10: code = 17; 11: code = 19;
        12: code = 0;  13: code = 1;  14: code = 15;    15: code = 23; 35, 43: code = 13;
        default: ill = 1;
      endcase
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_ov = 0; m_hl = 0; m_ill = 0; m_op = 0; m_acc = 0;
  endtask

  // Drives one cycle's inputs, advances the model, and returns at the next falling edge.
  task automatic cyc(input bit v, input int op, input int fn, input bit i21, input bit i6,
                     input bit i16, input bit fl);
    int code, lat;
    bit ill;
    In_Valid = v; Opcode = 6'(op); Funct = 6'(fn); I21 = i21; I6 = i6; I16 = i16; Flush = fl;
    ref_decode(op, fn, i21, i6, i16, code, ill, lat);
    m_acc = v && (m_rem == 0) && !fl;
    m_hl = 0;
    m_ov = 0;
    if (fl) m_rem = 0;
    else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin m_ov = 1; m_hl = 1; end
    end else if (m_acc) begin
      m_ill = ill;
      m_op  = ill ? 0 : code;
      if (!ill && lat > 0) m_rem = lat;
      else m_ov = 1;
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    Rst = 1'b0;
    model_reset();
    In_Valid = 0; Opcode = 0; Funct = 0; I21 = 0; I6 = 0; I16 = 0; Flush = 0;
    @(negedge Clk); @(negedge Clk);
    n_vec++;
    if (dut_vec !== 9'd0) begin
      n_err++; $display("FAIL reset_state got %b want %b", dut_vec, 9'd0);
    end
    Rst = 1'b1;
    idle();
    n_vec++;
    if (dut_vec !== model_out()) begin
      n_err++; $display("FAIL reset_idle got %b want %b", dut_vec, model_out());
    end
  endtask

  task automatic test_shift_pair();
    cyc(1, 0, 2, 1, 0, 0, 0);
    n_vec++;
    if (ALUOp !== 5'd9 || Out_Valid !== 1'b1 || Stall !== 1'b0) begin
      n_err++; $display("FAIL rotr aluop=%0d ov=%b stall=%b want 9 1 0", ALUOp, Out_Valid, Stall);
    end
    cyc(1, 0, 6, 0, 0, 0, 0);
    n_vec++;
    if (ALUOp !== 5'd5 || Out_Valid !== 1'b1 || Stall !== 1'b0) begin
      n_err++; $display("FAIL srlv aluop=%0d ov=%b stall=%b want 5 1 0", ALUOp, Out_Valid, Stall);
    end
    idle();
    n_vec++;
    if (Out_Valid !== 1'b0 || ALUOp !== 5'd5) begin
      n_err++; $display("FAIL idle_hold ov=%b aluop=%0d want 0 5", Out_Valid, ALUOp);
    end
  endtask

  task automatic test_madd(input int fn);
    int stall_cycles = 0;
    cyc(1, 28, fn, 0, 0, 0, 0);
    for (int i = 0; i < 10 && Stall === 1'b1; i++) begin
      stall_cycles++;
      n_vec++;
      if (Out_Valid !== 1'b0 || HiLoWrite !== 1'b0 || ALUOp !== 5'd31) begin
        n_err++; $display("FAIL madd_busy ov=%b hl=%b aluop=%0d want 0 0 31", Out_Valid, HiLoWrite, ALUOp);
      end
      idle();
    end
    n_vec++;
    if (stall_cycles != MUL_LAT || Out_Valid !== 1'b1 || HiLoWrite !== 1'b1 || ALUOp !== 5'd31) begin
      n_err++; $display("FAIL madd_done stall=%0d ov=%b hl=%b aluop=%0d want %0d 1 1 31",
                        stall_cycles, Out_Valid, HiLoWrite, ALUOp, MUL_LAT);
    end
    idle();
    n_vec++;
    if (Out_Valid !== 1'b0 || HiLoWrite !== 1'b0) begin
      n_err++; $display("FAIL madd_pulse ov=%b hl=%b want 0 0", Out_Valid, HiLoWrite);
    end
  endtask

  task automatic test_flush();
    cyc(1, 28, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (Stall !== 1'b0 || Out_Valid !== 1'b0 || HiLoWrite !== 1'b0) begin
      n_err++; $display("FAIL flush stall=%b ov=%b hl=%b want 0 0 0", Stall, Out_Valid, HiLoWrite);
    end
    for (int i = 0; i < MUL_LAT + 1; i++) begin
      idle();
      n_vec++;
      if (HiLoWrite !== 1'b0 || dut_vec !== model_out()) begin
        n_err++; $display("FAIL flush_after got %b want %b", dut_vec, model_out());
      end
    end
  endtask

  task automatic test_stall_hold();
    int holds = 0;
    cyc(1, 0, 24, 0, 0, 0, 0);
    do begin
      cyc(1, 1, 0, 0, 0, 1, 0);
      holds++;
      n_vec++;
      if (dut_vec !== model_out()) begin
        n_err++; $display("FAIL hold_cycle%0d got %b want %b", holds, dut_vec, model_out());
      end
    end while (!m_acc && holds < 20);
    n_vec++;
    if (holds != MUL_LAT + 1 || ALUOp !== 5'd18 || Out_Valid !== 1'b1) begin
      n_err++; $display("FAIL bgez_after_stall holds=%0d aluop=%0d ov=%b want %0d 18 1",
                        holds, ALUOp, Out_Valid, MUL_LAT + 1);
    end
    cyc(1, 1, 0, 0, 0, 0, 0);
    n_vec++;
    if (ALUOp !== 5'd12 || Out_Valid !== 1'b1) begin
      n_err++; $display("FAIL bltz aluop=%0d ov=%b want 12 1", ALUOp, Out_Valid);
    end
  endtask

  task automatic test_div();
    int stall_cycles = 0;
    cyc(1, 0, 26, 0, 0, 0, 0);
    for (int i = 0; i < 40 && Stall === 1'b1; i++) begin
      stall_cycles++;
      idle();
    end
`ifdef ALUCTRL_DIV_EN
    n_vec++;
    if (stall_cycles != DIV_LAT || ALUOp !== 5'd26 || HiLoWrite !== 1'b1 || Out_Valid !== 1'b1) begin
      n_err++; $display("FAIL div stall=%0d aluop=%0d hl=%b ov=%b want %0d 26 1 1",
                        stall_cycles, ALUOp, HiLoWrite, Out_Valid, DIV_LAT);
    end
`else
    n_vec++;
    if (stall_cycles != 0 || ALUOp !== 5'd0 || Illegal !== 1'b1 || Out_Valid !== 1'b1 || HiLoWrite !== 1'b0) begin
      n_err++; $display("FAIL div_illegal stall=%0d aluop=%0d ill=%b ov=%b hl=%b want 0 0 1 1 0",
                        stall_cycles, ALUOp, Illegal, Out_Valid, HiLoWrite);
    end
`endif
    cyc(1, 0, 37, 0, 0, 0, 0);
    n_vec++;
    if (Illegal !== 1'b0 || ALUOp !== 5'd1) begin
      n_err++; $display("FAIL illegal_clear ill=%b aluop=%0d want 0 1", Illegal, ALUOp);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 28, 0, 0, 0, 0, 0);
    idle();
    #2 Rst = 1'b0;
    #1;
    n_vec++;
    if (dut_vec !== 9'd0) begin
      n_err++; $display("FAIL async_reset got %b want %b", dut_vec, 9'd0);
    end
    model_reset();
    Rst = 1'b1;
    cyc(1, 12, 0, 0, 0, 0, 0);
    n_vec++;
    if (ALUOp !== 5'd0 || Out_Valid !== 1'b1 || Stall !== 1'b0 || Illegal !== 1'b0) begin
      n_err++; $display("FAIL andi_after_reset aluop=%0d ov=%b stall=%b ill=%b want 0 1 0 0",
                        ALUOp, Out_Valid, Stall, Illegal);
    end
  endtask

  task automatic test_random();
    int ops[20] = '{0, 0, 0, 1, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 28, 28, 35, 43, 2, 63};
    int f28[4]  = '{0, 2, 4, 1};
    int op, fn;
    for (int i = 0; i < 600; i++) begin
      op = ops[$urandom_range(0, 19)];
      fn = (op == 28) ? f28[$urandom_range(0, 3)] : int'($urandom_range(0, 63));
      cyc($urandom_range(0, 3) != 0, op, fn, 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 15) == 0);
      n_vec++;
      if (dut_vec !== model_out()) begin
        n_err++; $display("FAIL random_%0d op=%0d fn=%0d got %b want %b", i, op, fn, dut_vec, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_pair();
    test_madd(0);
    test_madd(2);
    test_flush();
    test_stall_hold();
    test_div();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
